// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: frame sequencer for a 3x3 matrix datapath with shadow/active coefficient banks
module matrix_seq_ctrl #(
    parameter int unsigned FRAME_SIZE = 76800,
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iCoefWr,
    input  logic [3:0]   iCoefAddr,
    input  logic [17:0]  iCoefData,
    input  logic         iCommit,
    input  logic         iValid,
    output logic         oReady,
    output logic         oPixValid,
    output logic [161:0] oCoef,
    output logic         oCommitPending,
    output logic         oFrameStart,
    output logic         oFrameDone,
    output logic [31:0]  oPixCnt,
    output logic [15:0]  oFrameCnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;
    localparam logic [31:0] LAST_PIX = 32'(FRAME_SIZE - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(PIPE_DEPTH - 1);
    state_t      state, state_nx;
    logic [17:0] coef_shadow [9];
    logic [17:0] coef_act [9];
    logic [31:0] pix_cnt;
    logic [15:0] frame_cnt;
    logic [3:0]  drain_cnt;
    logic        pending;
    logic        commit_req;
    logic        accept;
    logic        drain_end;
    // a commit raised this cycle in IDLE wins over a pixel arriving alongside it
    assign commit_req = pending | iCommit;
    always_comb begin
        state_nx = state;
        oReady   = 1'b0;
        case (state)
            IDLE: begin
                oReady   = ~commit_req;
                state_nx = commit_req ? COMMIT : iValid ? (LAST_PIX == 32'd0 ? DRAIN : RUN) : IDLE;
            end
            RUN: begin
                oReady   = 1'b1;
                state_nx = (iValid && pix_cnt == LAST_PIX) ? DRAIN : RUN;
            end
            DRAIN:   state_nx = (drain_cnt == LAST_DRAIN) ? IDLE : DRAIN;
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (reset)
            oReady = 1'b0;
    end
    assign accept         = iValid & oReady;
    assign oPixValid      = accept;
    assign oFrameStart    = accept && state == IDLE;
    assign drain_end      = !reset && state == DRAIN && drain_cnt == LAST_DRAIN;
    assign oFrameDone     = drain_end;
    assign oPixCnt        = pix_cnt;
    assign oFrameCnt      = frame_cnt;
    assign oCommitPending = pending;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            frame_cnt <= '0;
            drain_cnt <= '0;
            pending   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                coef_shadow[k] <= '0;
                coef_act[k]    <= '0;
            end
        end else begin
            state     <= state_nx;
            pending   <= iCommit | (pending & (state != COMMIT));
            pix_cnt   <= drain_end ? '0 : accept ? pix_cnt + 32'd1 : pix_cnt;
            frame_cnt <= frame_cnt + {15'd0, drain_end};
            drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : '0;
            if (iCoefWr && iCoefAddr < 4'd9)
                coef_shadow[iCoefAddr] <= iCoefData;
            // the copy samples the shadow as it stood before any write landing in this same cycle
            if (state == COMMIT)
                for (int k = 0; k < 9; k++)
                    coef_act[k] <= coef_shadow[k];
        end
    end
    for (genvar i = 0; i < 9; i++) begin : g_pack
        assign oCoef[161-18*i -: 18] = coef_act[i];
    end
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// tb_matrix_seq_ctrl: randomized and directed checks against an event-timed frame model
module tb_matrix_seq_ctrl;
    localparam int FS = 4;
    localparam int PD = 3;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         iCoefWr = 1'b0;
    logic [3:0]   iCoefAddr = '0;
    logic [17:0]  iCoefData = '0;
    logic         iCommit = 1'b0;
    logic         iValid = 1'b0;
    logic         oReady, oPixValid, oCommitPending, oFrameStart, oFrameDone;
    logic [161:0] oCoef;
    logic [31:0]  oPixCnt;
    logic [15:0]  oFrameCnt;

    matrix_seq_ctrl #(.FRAME_SIZE(FS), .PIPE_DEPTH(PD)) dut (
        .clk(clk), .reset(reset), .iCoefWr(iCoefWr), .iCoefAddr(iCoefAddr),
        .iCoefData(iCoefData), .iCommit(iCommit), .iValid(iValid), .oReady(oReady),
        .oPixValid(oPixValid), .oCoef(oCoef), .oCommitPending(oCommitPending),
        .oFrameStart(oFrameStart), .oFrameDone(oFrameDone), .oPixCnt(oPixCnt),
        .oFrameCnt(oFrameCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    // model: pixels in the open frame, cycle at which its done pulse is due, pending copy
    int          m_cnt, m_done_at, m_frames, cyc;
    bit          m_pending, m_commit_now;
    logic [17:0] m_shadow [9];
    logic [17:0] m_active [9];
    int          n_acc, last_acc, last_done;
    logic [161:0] exp_pk;
    bit          done_seen;

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [161:0] pack_active();
        logic [161:0] p;
        for (int k = 0; k < 9; k++) p[161-18*k -: 18] = m_active[k];
        return p;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_done_at = -1; m_frames = 0; cyc = 0;
        m_pending = 0; m_commit_now = 0;
        for (int k = 0; k < 9; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
    endtask

    // called at a falling edge with inputs already driven; checks, advances the model, waits one cycle
    task automatic step();
        bit busy, er, ea, es, ed, nxt_commit;
        #1;
        if (reset) begin
            chk("rst_done", 162'(oFrameDone), 162'(0));
            chk("rst_start", 162'(oFrameStart), 162'(0));
            model_reset();
        end else begin
            busy = (m_done_at >= 0) || m_commit_now;
            er = !busy && (m_cnt > 0 || !(m_pending || iCommit));
            ea = er && iValid;
            es = ea && m_cnt == 0;
            ed = (m_done_at == cyc);
            chk("ready", 162'(oReady), 162'(er));
            chk("pixvalid", 162'(oPixValid), 162'(ea));
            chk("framestart", 162'(oFrameStart), 162'(es));
            chk("framedone", 162'(oFrameDone), 162'(ed));
            chk("pixcnt", 162'(oPixCnt), 162'(m_cnt));
            chk("framecnt", 162'(oFrameCnt), 162'(m_frames));
            chk("pending", 162'(oCommitPending), 162'(m_pending));
            chk("coef", oCoef, pack_active());
            if (oPixValid) begin n_acc++; last_acc = cyc; end
            if (oFrameDone) last_done = cyc;
            nxt_commit = !m_commit_now && m_done_at < 0 && m_cnt == 0 && (m_pending || iCommit);
            if (m_commit_now)
                for (int k = 0; k < 9; k++) m_active[k] = m_shadow[k];
            m_pending = iCommit || (m_pending && !m_commit_now);
            if (iCoefWr && iCoefAddr < 9) m_shadow[iCoefAddr] = iCoefData;
            if (ea) begin
                m_cnt++;
                if (m_cnt == FS) m_done_at = cyc + PD;
            end
            if (ed) begin
                m_frames = (m_frames + 1) % 65536;
                m_cnt = 0;
                m_done_at = -1;
            end
            m_commit_now = nxt_commit;
            cyc++;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        n_acc = 0; last_acc = -1; last_done = -1;
        for (int k = 0; k < 9; k++) exp_pk[161-18*k -: 18] = 18'(k + 1);
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        #1;
        chk("lit_reset_ready", 162'(oReady), 162'(1));
        chk("lit_reset_coef", oCoef, 162'(0));
        chk("lit_reset_pixcnt", 162'(oPixCnt), 162'(0));
        // full frame with iValid held high
        iValid = 1'b1;
        for (int i = 0; i < 7; i++) step();
        iValid = 1'b0;
        #1;
        chk("lit_accepts_0_6", 162'(n_acc), 162'(4));
        chk("lit_last_accept", 162'(last_acc), 162'(3));
        chk("lit_done_cycle", 162'(last_done), 162'(6));
        chk("lit_framecnt1", 162'(oFrameCnt), 162'(1));
        chk("lit_ready_c7", 162'(oReady), 162'(1));
        // shadow load then commit in IDLE
        for (int k = 0; k < 9; k++) begin
            iCoefWr = 1'b1; iCoefAddr = 4'(k); iCoefData = 18'(k + 1);
            step();
        end
        iCoefWr = 1'b0; iCommit = 1'b1;
        step();
        iCommit = 1'b0;
        #1;
        chk("lit_commit_ready0", 162'(oReady), 162'(0));
        chk("lit_commit_pend", 162'(oCommitPending), 162'(1));
        step();
        #1;
        chk("lit_coef0", 162'(oCoef[161:144]), 162'(1));
        chk("lit_coef8", 162'(oCoef[17:0]), 162'(9));
        chk("lit_pend_clear", 162'(oCommitPending), 162'(0));
        // out-of-range shadow write
        iCoefWr = 1'b1; iCoefAddr = 4'd12; iCoefData = 18'h3FFFF; iCommit = 1'b1;
        step();
        iCoefWr = 1'b0; iCommit = 1'b0;
        step(); step();
        chk("lit_addr12_ignored", oCoef, exp_pk);
        // commit requested mid-frame is deferred past the frame's done pulse
        iValid = 1'b1;
        step();
        iCommit = 1'b1; iCoefWr = 1'b1; iCoefAddr = 4'd0; iCoefData = 18'd77;
        step();
        iCommit = 1'b0; iCoefWr = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10 && !done_seen; i++) begin
            #1;
            if (oFrameDone) done_seen = 1;
            else step();
        end
        chk("lit_done_seen", 162'(done_seen), 162'(1));
        chk("lit_coef_held", oCoef, exp_pk);
        step();
        #1;
        chk("lit_idle_pend_ready", 162'(oReady), 162'(0));
        step();
        #1;
        chk("lit_commit_cycle_ready", 162'(oReady), 162'(0));
        step();
        #1;
        chk("lit_new_coef0", 162'(oCoef[161:144]), 162'(77));
        chk("lit_restart", 162'(oFrameStart), 162'(1));
        step();
        for (int i = 0; i < 3; i++) step();
        iValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        // toggled valid
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            iValid = (i < 8) && (i % 2 == 0);
            step();
            if (i == 2) chk("lit_toggle_pixcnt", 162'(oPixCnt), 162'(2));
        end
        chk("lit_toggle_accepts", 162'(n_acc), 162'(4));
        chk("lit_toggle_latency", 162'(last_done - last_acc), 162'(3));
        // reset during drain cycle 1
        iValid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1; iValid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("lit_abort_pixcnt", 162'(oPixCnt), 162'(0));
        chk("lit_abort_coef", oCoef, 162'(0));
        chk("lit_abort_ready", 162'(oReady), 162'(1));
        chk("lit_abort_framecnt", 162'(oFrameCnt), 162'(0));
        step();
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            iValid    = ($urandom_range(0, 9) < 7);
            iCommit   = ($urandom_range(0, 19) == 0);
            iCoefWr   = ($urandom_range(0, 4) == 0);
            iCoefAddr = 4'($urandom_range(0, 15));
            iCoefData = 18'($urandom);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
